aes_job_sched: RTL
==================

# aes_job_sched

Job-level scheduler placing one shared AES cipher engine between two requester channels. Each job is a key load followed by a stream of 128-bit blocks ending in a last block. The block arbitrates round-robin per job and drives key init and block transfer into the engine. It tracks in-flight blocks and tags engine output with the owning channel and end-of-job. It sits between the per-channel crypto front ends and the AES engine instance.

## Interface
Parameters:
- MAX_OUTST, 4: maximum blocks accepted by the engine but not yet returned (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ReqVld  in  2  per-channel job request, held until granted
- ReqKey  in  512  keys; channel n at [256n+255:256n]
- ReqKsz  in  4  key size; channel n at [2n+1:2n]; 00=128, 01=192, 10=256, 11=256
- ReqEnc  in  2  1=encrypt, 0=decrypt
- ReqGnt  out  2  one-hot, single-cycle job accept
- BlkIn  in  256  block data; channel n at [128n+127:128n]
- BlkVld, BlkLast  in  2 each  block valid, last block of job
- BlkRdy  out  2  block accepted when BlkVld[n]&BlkRdy[n]
- OutData  out  128  engine result (pass-through)
- OutVld  out  1  result valid
- OutCh  out  1  owning channel of result
- OutLast  out  1  final result of job
- OutStall  in  1  downstream backpressure
- AesAes128/AesAes192/AesAes256  out  1 each  one-hot key-size select
- AesKeyIn  out  256  latched key
- AesKeyInitVld  out  1  key-load request
- AesEncryptEn  out  1  latched direction
- AesCiphIn  out  128  block to engine
- AesCiphInVld, AesCiphInLast  out  1 each
- AesKeyInitStall, AesCiphInStall  in  1 each  engine backpressure
- AesCiphOut  in  128; AesCiphOutVld  in  1; AesCiphOutStall  out  1
- Busy  out  1  state != IDLE
- Err  out  1  sticky: engine result arrived with zero outstanding

## Operation
- States: IDLE, KEY, DATA, DRAIN. All registers reset to IDLE, sel=0, rr pointer=0, outstanding=0, lastSent=0, Err=0. Latched key, size and enc reset to 0.
- IDLE: if any ReqVld, pick a channel. When both request, the channel pointed to by rr wins; otherwise the sole requester wins. ReqGnt[sel]=1 combinationally this cycle. Latch ReqKey, ReqKsz and ReqEnc of the winner, plus sel, then go to KEY.
- KEY: AesKeyInitVld=1. The load is accepted on a cycle with AesKeyInitStall=0, then go to DATA.
- DATA: AesCiphIn/AesCiphInVld/AesCiphInLast mirror BlkIn/BlkVld/BlkLast of sel, gated by credit (outstanding < MAX_OUTST). BlkRdy[sel] = credit & !AesCiphInStall. BlkRdy of the other channel is 0. A transfer with BlkLast sets lastSent and goes to DRAIN.
- DRAIN: no new input. When outstanding==0, go to IDLE, set rr = ~sel, clear lastSent.
- outstanding: +1 on transfer, -1 on output handshake (AesCiphOutVld & !OutStall). A simultaneous +1/-1 leaves it unchanged. Width is ceil(log2(MAX_OUTST+1)).
- Output: OutData=AesCiphOut, OutVld=AesCiphOutVld, AesCiphOutStall=OutStall, OutCh=sel. OutLast = OutVld & lastSent & outstanding==1.
- AesAes128/192/256 decode the latched size. They and AesKeyIn/AesEncryptEn hold stable from KEY through DRAIN.
- Engine result when outstanding==0: set Err, leave the counter at 0 (no underflow), still pass it through with OutLast=0.
- Reset mid-job: return to IDLE immediately and drop all context. The engine must be reset in the same cycle.

## Timing
- ReqVld in IDLE at cycle t: ReqGnt at t, AesKeyInitVld at t+1. With no stalls, the first block transfer is at t+2.
- Sustained throughput is one block per cycle while credit holds and AesCiphInStall=0.
- Last result handshake at cycle u: state is IDLE at u+1, and the next ReqGnt can occur at u+1.
- No gaps are inserted on the output path; it is zero-latency pass-through.

## Test plan
- Single job, ch0: ReqKsz=10, ReqEnc=1, 3 blocks, no stalls, engine echoes after 2 cycles. Required: ReqGnt=01 at t, KeyInitVld at t+1, AesAes256=1, 3 results with OutCh=0, OutLast only on the third, Busy low after.
- Both channels request in the same cycle from reset: ch0 granted first. After ch0 drains, ch1 is granted, then with both requesting again ch0 wins (alternation).
- Credit limit, MAX_OUTST=4: engine withholds output. Required: exactly 4 transfers, BlkRdy stays 0 until the first result handshake, then 1 transfer is allowed.
- AesKeyInitStall held 5 cycles. Required: AesKeyInitVld stays high for 6 cycles and no BlkRdy before acceptance. OutStall held 3 cycles mid-stream: outstanding is not decremented and OutVld stays asserted.
- Spurious AesCiphOutVld in IDLE: Err rises and stays set, outstanding stays 0. Reset asserted in DATA with 2 outstanding: next cycle IDLE, outstanding=0, Err=0, all ReqGnt/BlkRdy=0.

Source files
------------

// File: rtl/aes_job_sched.sv
`default_nettype none
// ============================================================================
// aes_job_sched : round-robin job scheduler in front of one shared AES engine
// Rev 1.0
// ============================================================================
module aes_job_sched #(
  parameter int MAX_OUTST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   ReqVld,
  input  logic [511:0] ReqKey,
  input  logic [3:0]   ReqKsz,
  input  logic [1:0]   ReqEnc,
  output logic [1:0]   ReqGnt,
  input  logic [255:0] BlkIn,
  input  logic [1:0]   BlkVld,
  input  logic [1:0]   BlkLast,
  output logic [1:0]   BlkRdy,
  output logic [127:0] OutData,
  output logic         OutVld,
  output logic         OutCh,
  output logic         OutLast,
  input  logic         OutStall,
  output logic         AesAes128,
  output logic         AesAes192,
  output logic         AesAes256,
  output logic [255:0] AesKeyIn,
  output logic         AesKeyInitVld,
  output logic         AesEncryptEn,
  output logic [127:0] AesCiphIn,
  output logic         AesCiphInVld,
  output logic         AesCiphInLast,
  input  logic         AesKeyInitStall,
  input  logic         AesCiphInStall,
  input  logic [127:0] AesCiphOut,
  input  logic         AesCiphOutVld,
  output logic         AesCiphOutStall,
  output logic         Busy,
  output logic         Err
);
  localparam int            CW    = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] C_MAX = CW'(MAX_OUTST);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEY   = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic          rr_q, rr_d;
  logic          last_sent_q, last_sent_d;
  logic          err_q, err_d;
  logic          enc_q, enc_d;
  logic [1:0]    ksz_q, ksz_d;
  logic [255:0]  key_q, key_d;
  logic [CW-1:0] outst_q, outst_d;

  logic win, credit, in_open, rdy, xfer, out_hs, dec;

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    rr_d          = rr_q;
    last_sent_d   = last_sent_q;
    enc_d         = enc_q;
    ksz_d         = ksz_q;
    key_d         = key_q;
    ReqGnt        = 2'b00;
    BlkRdy        = 2'b00;
    AesKeyInitVld = 1'b0;

    credit        = (outst_q < C_MAX);
    in_open       = (state_q == DATA) && credit;
    rdy           = in_open & ~AesCiphInStall;
    AesCiphInVld  = in_open & BlkVld[sel_q];
    AesCiphInLast = in_open & BlkLast[sel_q];
    BlkRdy[sel_q] = rdy;
    xfer          = rdy & BlkVld[sel_q];

    // A result with nothing outstanding is flagged but never underflows the count
    out_hs = AesCiphOutVld & ~OutStall;
    dec    = out_hs & (outst_q != '0);
    err_d  = err_q | (AesCiphOutVld & (outst_q == '0));
    case ({xfer, dec})
      2'b10:   outst_d = outst_q + C_ONE;
      2'b01:   outst_d = outst_q - C_ONE;
      default: outst_d = outst_q;
    endcase

    win = (ReqVld == 2'b11) ? rr_q : ReqVld[1];

    case (state_q)
      IDLE: begin
        if (|ReqVld) begin
          ReqGnt[win] = 1'b1;
          sel_d       = win;
          key_d       = win ? ReqKey[511:256] : ReqKey[255:0];
          ksz_d       = win ? ReqKsz[3:2] : ReqKsz[1:0];
          enc_d       = ReqEnc[win];
          state_d     = KEY;
        end
      end
      KEY: begin
        AesKeyInitVld = 1'b1;
        if (!AesKeyInitStall) state_d = DATA;
      end
      DATA: begin
        if (xfer && BlkLast[sel_q]) begin
          last_sent_d = 1'b1;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        // Leave on the cycle of the final handshake so the next grant is not delayed
        if (outst_d == '0) begin
          state_d     = IDLE;
          rr_d        = ~sel_q;
          last_sent_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      rr_q        <= 1'b0;
      last_sent_q <= 1'b0;
      err_q       <= 1'b0;
      enc_q       <= 1'b0;
      ksz_q       <= 2'b00;
      key_q       <= '0;
      outst_q     <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_q        <= rr_d;
      last_sent_q <= last_sent_d;
      err_q       <= err_d;
      enc_q       <= enc_d;
      ksz_q       <= ksz_d;
      key_q       <= key_d;
      outst_q     <= outst_d;
    end
  end

  assign AesCiphIn       = sel_q ? BlkIn[255:128] : BlkIn[127:0];
  assign AesKeyIn        = key_q;
  assign AesEncryptEn    = enc_q;
  assign AesAes128       = (ksz_q == 2'b00);
  assign AesAes192       = (ksz_q == 2'b01);
  assign AesAes256       = ksz_q[1];
  assign OutData         = AesCiphOut;
  assign OutVld          = AesCiphOutVld;
  assign OutCh           = sel_q;
  assign OutLast         = AesCiphOutVld & last_sent_q & (outst_q == C_ONE);
  assign AesCiphOutStall = OutStall;
  assign Busy            = (state_q != IDLE);
  assign Err             = err_q;

endmodule
`default_nettype wire
